// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one valid/ready data-memory access per request, extended load data or fault.
// Optional LSU_ALIGN_EXC_EN: misaligned half/word and reserved size fault without a bus cycle.
module lsu #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_fault_q, rsp_fault_d;

    logic [1:0]    eff_size;
    logic [3:0]    req_be;
    logic [31:0]   req_wd;
    logic          align_fault;
    logic [31:0]   rd_shift;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic          timeout_hit;

    // Lane steering of the incoming request, evaluated only at acceptance.
    always_comb begin
        eff_size    = req_size;
        align_fault = 1'b0;
`ifdef LSU_ALIGN_EXC_EN
        case (req_size)
            2'b01:   align_fault = req_addr[0];
            2'b10:   align_fault = (req_addr[1:0] != 2'b00);
            2'b11:   align_fault = 1'b1;
            default: align_fault = 1'b0;
        endcase
`else
        if (req_size == 2'b11) begin
            eff_size = 2'b10;
        end
`endif
        case (eff_size)
            2'b00: begin
                req_be = 4'b0001 << req_addr[1:0];
                req_wd = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_be = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wd = {2{req_wdata[15:0]}};
            end
            default: begin
                req_be = 4'b1111;
                req_wd = req_wdata;
            end
        endcase
    end

    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        rd_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_data = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_data = mem_rdata;
        endcase
    end

    // The counter reaching TIMEOUT-1 marks the TIMEOUT-th bus cycle; mem_ready on it still wins.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d = eff_size;
                    uns_d  = req_unsigned;
                    off_d  = req_addr[1:0];
                    if (align_fault) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else begin
                        state_d     = BUS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wd;
                    end
                end
            end
            BUS: begin
                if (mem_ready) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_we_q ? 32'h0 : load_data;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = ~req_ready;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu: reference model, randomized accesses, timeout and reset cases.
module tb_lsu;
    localparam int unsigned TO = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        busy;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .busy(busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } rsp_t;

    bus_t        bus_q[$];
    rsp_t        rsp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          plan_waits = 0;
    logic [31:0] plan_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: raises mem_ready after plan_waits bus cycles; random noise outside bus cycles.
    int bus_cnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ready = (bus_cnt == plan_waits);
            mem_rdata = mem_ready ? plan_rdata : $urandom;
            bus_cnt++;
        end else begin
            bus_cnt   = 0;
            mem_ready = 1'($urandom % 2);
            mem_rdata = $urandom;
        end
    end

    bit   in_bus = 0;
    bit   has_cur = 0;
    int   bus_len = 0;
    bus_t cur;
    rsp_t got;

    always @(negedge clk) begin
        if (!rstn) begin
            in_bus = 0;
        end else begin
            if (mem_req) begin
                if (!in_bus) begin
                    in_bus  = 1;
                    bus_len = 1;
                    if (bus_q.size() == 0) begin
                        has_cur = 0;
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bus: mem_req=1 addr %h, required no bus cycle", mem_addr);
                    end else begin
                        has_cur = 1;
                        cur = bus_q.pop_front();
                        chk("bus_addr", mem_addr, cur.addr);
                        chk("bus_be", {28'h0, mem_be}, {28'h0, cur.be});
                        chk("bus_we", {31'h0, mem_we}, {31'h0, cur.we});
                        if (cur.we) chk("bus_wdata", mem_wdata, cur.wdata);
                    end
                end else begin
                    bus_len++;
                    if (has_cur) begin
                        chk("bus_hold_addr", mem_addr, cur.addr);
                        chk("bus_hold_be", {28'h0, mem_be}, {28'h0, cur.be});
                    end
                end
            end else if (in_bus) begin
                in_bus = 0;
                if (has_cur) chk("bus_len", bus_len, cur.len);
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 rdata %h, required no response", rsp_rdata);
                end else begin
                    got = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, got.rdata);
                    chk("rsp_fault", {31'h0, rsp_fault}, {31'h0, got.fault});
                    chk("rsp_cycle", cyc, got.cyc);
                end
            end
        end
    end

    // Reference behaviour: an access touches n bytes starting at the n-aligned lane of the word.
    function automatic void model(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output bit f, output logic [3:0] be, output logic [31:0] wd,
                                  output logic [31:0] ld);
        int n;
        int lane0;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        f = 0;
`ifdef LSU_ALIGN_EXC_EN
        if (size == 2'd3 || (addr % n) != 0) f = 1;
`endif
        lane0 = (int'(addr[1:0]) / n) * n;
        be = 4'h0;
        ld = 32'h0;
        for (int i = 0; i < n; i++) begin
            be[lane0 + i] = 1'b1;
            ld = ld | (((rdata >> (8 * (lane0 + i))) & 32'hff) << (8 * i));
        end
        if (!uns && n < 4 && ld[8 * n - 1]) ld = ld | (32'hFFFF_FFFF << (8 * n));
        for (int j = 0; j < 4; j++) wd[8 * j +: 8] = wdata[8 * (j % n) +: 8];
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL %s: req_ready still 0 after %0d cycles, required 1", name, n);
            $fatal(1);
        end
    endtask

    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                          input logic [31:0] rdata, input bit abort);
        bit          f;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        bit          tmo;
        int          lat;
        bus_t        b;
        rsp_t        r;
        wait_ready("req_ready_before");
        model(size, uns, addr, wdata, rdata, f, be, wd, ld);
        tmo = !f && (waits >= int'(TO));
        lat = f ? 1 : (tmo ? 1 + int'(TO) : 2 + waits);
        plan_waits = waits;
        plan_rdata = rdata;
        r.rdata = (f || tmo || we) ? 32'h0 : ld;
        r.fault = f || tmo;
        r.cyc   = cyc + lat;
        rsp_q.push_back(r);
        if (!f) begin
            b.addr  = {addr[31:2], 2'b00};
            b.be    = be;
            b.we    = we;
            b.wdata = wd;
            b.len   = tmo ? int'(TO) : waits + 1;
            bus_q.push_back(b);
        end
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom % 2); req_size = 2'($urandom % 4); req_unsigned = 1'($urandom % 2);
        req_addr = $urandom; req_wdata = $urandom;
        chk("busy_after_accept", {31'h0, busy}, 32'h1);
        if (abort) begin
            @(negedge clk);
            @(posedge clk);
            #2 rstn = 1'b0;
            #1;
            chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
            chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
            chk("rst_busy", {31'h0, busy}, 32'h0);
            chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
            rsp_q.delete();
            repeat (3) @(negedge clk);
            rstn = 1'b1;
        end else begin
            wait_ready("req_ready_after");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #12;
        chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
        chk("reset_mem_we", {31'h0, mem_we}, 32'h0);
        chk("reset_mem_be", {28'h0, mem_be}, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_fault", {31'h0, rsp_fault}, 32'h0);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        access(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234, 1'b0);
        access(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234, 1'b0);
        access(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 0, 32'h1357_9BDF, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 5, 32'hCAFE_F00D, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, 100, 32'h1111_2222, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0041, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 2'd1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h8001_7FFE, 1'b0);
        access(1'b0, 2'd3, 1'b1, 32'h0000_0060, 32'h0, 0, 32'h0BAD_CAFE, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 100, 32'h0, 1'b1);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 1, 32'h7654_3210, 1'b0);

        for (int k = 0; k < 60; k++) begin
            int w;
            int sel;
            sel = int'($urandom_range(0, 9));
            w = (sel < 8) ? int'($urandom_range(0, 3)) : (sel == 8) ? int'(TO) - 1 : 50;
            access(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), $urandom, $urandom,
                   w, $urandom, 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("rsp_queue_drained", rsp_q.size(), 32'h0);
        chk("bus_queue_drained", bus_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
